// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : EX-stage HI/LO multiply/divide unit. Runs MULT/MULTU/DIV/DIVU
//            iteratively, owns HI/LO, services MFHI/MFLO/MTHI/MTLO and
//            raises a stall while a HI/LO access meets an op in flight.
// Options  : MULDIV_FAST_MUL_EN - single-cycle array multiply for
//            MULT/MULTU (IDLE -> FIX); division stays iterative.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_id_ex,
  input  logic [5:0]      opcode_id_ex,
  input  logic [5:0]      func_id_ex,
  input  logic [XLEN-1:0] rd0_data_id_ex,
  input  logic [XLEN-1:0] rd1_data_id_ex,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hilo_result,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] acc;     // mul: {partial, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]   opnd;    // multiplicand / divisor magnitude
  logic              op_div;
  logic              neg_q;   // negate product / quotient in FIX
  logic              neg_r;   // negate remainder in FIX

  // Instruction decode
  logic r_type, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_mult, is_multu, is_div, is_divu, start, hilo_op, signed_op, div_zero;

  assign r_type    = valid_id_ex && (opcode_id_ex == 6'h00);
  assign is_mfhi   = r_type && (func_id_ex == FUNC_MFHI);
  assign is_mflo   = r_type && (func_id_ex == FUNC_MFLO);
  assign is_mthi   = r_type && (func_id_ex == FUNC_MTHI);
  assign is_mtlo   = r_type && (func_id_ex == FUNC_MTLO);
  assign is_mult   = r_type && (func_id_ex == FUNC_MULT);
  assign is_multu  = r_type && (func_id_ex == FUNC_MULTU);
  assign is_div    = r_type && (func_id_ex == FUNC_DIV);
  assign is_divu   = r_type && (func_id_ex == FUNC_DIVU);
  assign start     = is_mult || is_multu || is_div || is_divu;
  assign hilo_op   = start || is_mfhi || is_mflo || is_mthi || is_mtlo;
  assign signed_op = is_mult || is_div;
  assign div_zero  = (is_div || is_divu) && (rd1_data_id_ex == '0);

  assign busy  = (state != IDLE);
  assign stall = busy && hilo_op;

  // Operand magnitudes; 0x80000000 negates to itself, i.e. unsigned 2^31
  logic [XLEN-1:0] mag_a, mag_b;
  assign mag_a = (signed_op && rd0_data_id_ex[XLEN-1]) ? -rd0_data_id_ex : rd0_data_id_ex;
  assign mag_b = (signed_op && rd1_data_id_ex[XLEN-1]) ? -rd1_data_id_ex : rd1_data_id_ex;

  // Multiply step: conditional add into upper half, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opnd};
  assign mul_step = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: shift left, trial subtract, keep if no borrow
  logic [2*XLEN-1:0] div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_step;
  assign div_shift = {acc[2*XLEN-2:0], 1'b0};
  assign div_diff  = {1'b0, div_shift[2*XLEN-1:XLEN]} - {1'b0, opnd};
  assign div_step  = div_diff[XLEN] ? div_shift
                                    : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            state_next = FIX;
`ifdef MULDIV_FAST_MUL_EN
          end else if (is_mult || is_multu) begin
            state_next = FIX;
`endif
          end else begin
            state_next = ITER;
          end
        end
      end
      ITER:    if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO writes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // stall is never raised in IDLE, so any start seen here is taken
          if (start) begin
            cnt    <= '0;
            op_div <= is_div || is_divu;
            if (div_zero) begin
              acc   <= {rd0_data_id_ex, {XLEN{1'b1}}};
              opnd  <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (is_div || is_divu) begin
              acc   <= {{XLEN{1'b0}}, mag_a};
              opnd  <= mag_b;
              neg_q <= signed_op && (rd0_data_id_ex[XLEN-1] ^ rd1_data_id_ex[XLEN-1]);
              neg_r <= signed_op && rd0_data_id_ex[XLEN-1];
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc   <= (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`else
              acc   <= {{XLEN{1'b0}}, mag_b};
`endif
              opnd  <= mag_a;
              neg_q <= signed_op && (rd0_data_id_ex[XLEN-1] ^ rd1_data_id_ex[XLEN-1]);
              neg_r <= 1'b0;
            end
          end else if (is_mthi) begin
            hi <= rd0_data_id_ex;
          end else if (is_mtlo) begin
            lo <= rd0_data_id_ex;
          end
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          acc <= op_div ? div_step : mul_step;
        end
        FIX: begin
          if (op_div) begin
            lo <= neg_q ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
            hi <= neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

  // MFHI/MFLO read port
  always_comb begin
    hilo_result = '0;
    if (is_mfhi)      hilo_result = hi;
    else if (is_mflo) hilo_result = lo;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Directed bench for ex_muldiv; expected HI/LO/latency pushed to a
//            scoreboard queue at issue and popped when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] rs, rt;
  logic        stall, busy;
  logic [31:0] hilo_result, hi, lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_id_ex    (valid),
    .opcode_id_ex   (opcode),
    .func_id_ex     (func),
    .rd0_data_id_ex (rs),
    .rd1_data_id_ex (rt),
    .stall          (stall),
    .busy           (busy),
    .hilo_result    (hilo_result),
    .hi             (hi),
    .lo             (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    valid = v; opcode = op; func = f; rs = a; rt = b;
  endtask

  // Reference model: {HI, LO} from 64-bit arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb_, sq, sr;
    logic [63:0] ua, ub;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (f)
      6'h18: return sa * sb_;
      6'h19: return ua * ub;
      6'h1A: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        sq = sa / sb_;
        sr = sa % sb_;
        return {sr[31:0], sq[31:0]};
      end
      6'h1B: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issue one op at a negedge with the unit idle, wait for busy to fall, check
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi,
                        input logic [31:0] elo, input int ecyc, input bit probe);
    exp_t e;
    int   cyc;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.cyc = ecyc;
    sb.push_back(e);
    drive(1'b1, 6'h00, f, a, b);
    @(negedge clk);
    if (probe) begin
      drive(1'b1, 6'h23, 6'h00, 32'h1, 32'h2);
      #1;
      chk({tag, "_passthru_stall"}, {31'b0, stall}, 32'h0);
      chk({tag, "_passthru_busy"},  {31'b0, busy},  32'h1);
    end
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({e.tag, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
    chk({e.tag, "_hi"}, hi, e.hi);
    chk({e.tag, "_lo"}, lo, e.lo);
  endtask

  initial begin
    exp_t e;
    int   cyc;
    logic [63:0] m;
    logic [5:0]  f;
    logic [31:0] a, b;

    rst = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_hi",    hi,               32'h0);
    chk("reset_lo",    lo,               32'h0);
    chk("reset_busy",  {31'b0, busy},    32'h0);
    chk("reset_stall", {31'b0, stall},   32'h0);
    chk("reset_hilo",  hilo_result,      32'h0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI / MTLO then read back through MFHI / MFLO
    drive(1'b1, 6'h00, 6'h11, 32'hA5A5_0001, 32'h0);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h13, 32'h5A5A_0002, 32'h0);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    chk("mfhi_read", hilo_result, 32'hA5A5_0001);
    chk("mthi_port", hi,          32'hA5A5_0001);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    chk("mflo_read", hilo_result, 32'h5A5A_0002);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h20, 32'h0, 32'h0);
    #1;
    chk("hilo_other_func", hilo_result, 32'h0);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);

    // Directed arithmetic cases
    run_op("mult_neg",   6'h18, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYC, 1'b0);
    run_op("multu_big",  6'h19, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MUL_CYC, 1'b0);
    run_op("div_neg",    6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC, 1'b0);
    run_op("divu_100_7", 6'h1B, 32'd100,      32'd7, 32'd2,        32'd14,       DIV_CYC, 1'b1);
    run_op("divu_by0",   6'h1B, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 1,       1'b0);
    run_op("div_by0",    6'h1A, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1,       1'b0);
    run_op("div_ovf",    6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_CYC, 1'b0);
    run_op("mult_min",   6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, MUL_CYC, 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 4; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      m = model(f, a, b);
      run_op("rand", f, a, b, m[63:32], m[31:0],
             (f <= 6'h19) ? MUL_CYC : ((b == 32'h0) ? 1 : DIV_CYC), 1'b0);
    end

    // MULT 6x7 immediately followed by MFLO: stall until busy drops
    e.tag = "mult_mflo"; e.hi = 32'h0; e.lo = 32'd42; e.cyc = MUL_CYC;
    sb.push_back(e);
    drive(1'b1, 6'h00, 6'h18, 32'd6, 32'd7);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    chk({e.tag, "_stall_cycles"}, 32'(cyc), 32'(e.cyc));
    chk({e.tag, "_busy_low"},     {31'b0, busy}, 32'h0);
    chk({e.tag, "_mflo"},         hilo_result, e.lo);
    chk({e.tag, "_hi"},           hi, e.hi);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);

    // Reset during a fresh DIV aborts it and clears HI/LO
    drive(1'b1, 6'h00, 6'h1A, 32'd100, 32'd7);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_hi",   hi,            32'h0);
    chk("rst_mid_lo",   lo,            32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("rst_after_hi", hi, 32'h0);
    chk("rst_after_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
